btn_debounce_bank: RTL and testbench

//  Multi-channel push-button debouncer with built-in sample-rate prescaler; successor to the fixed 25M toggle clock divider.

---
 rtl/debounce_pkg.sv | 23 ++
 rtl/debounce_ch.sv | 109 ++++++++++
 rtl/btn_debounce_bank.sv | 57 +++++
 tb/tb_btn_debounce_bank.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debouncer bank.
// Optional fall pulse is controlled by DEBOUNCE_FALL_PULSE_EN (see debounce_ch / btn_debounce_bank).
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } ch_state_e;

  localparam int DEF_CLK_HZ    = 100_000_000;
  localparam int DEF_SAMPLE_HZ = 1_000;

  // Ceil-log2 that never returns 0, so it is always usable as a vector width.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debouncer channel: 2-flop synchroniser, N-sample stability FSM, edge pulses.
// btn_fall output only exists when DEBOUNCE_FALL_PULSE_EN is defined.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_in,
  output logic db,
  output logic rise
`ifdef DEBOUNCE_FALL_PULSE_EN
  ,
  output logic fall
`endif
);

  localparam int            CW   = clog2_min1(STABLE_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);

  logic          s1, s2;
  ch_state_e     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // cnt holds the number of agreeing samples already seen while pending.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE_LO;
      cnt   <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
      fall  <= 1'b0;
`endif
    end else begin
      rise <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
      fall <= 1'b0;
`endif
      if (tick) begin
        unique case (state)
          STABLE_LO: if (s2) begin
            if (STABLE_CNT == 1) begin
              state <= STABLE_HI;
              db    <= 1'b1;
              rise  <= 1'b1;
            end else begin
              state <= PEND_HI;
              cnt   <= CW'(1);
            end
          end
          PEND_HI: begin
            if (!s2) begin
              state <= STABLE_LO;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state <= STABLE_HI;
              cnt   <= '0;
              db    <= 1'b1;
              rise  <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          STABLE_HI: if (!s2) begin
            if (STABLE_CNT == 1) begin
              state <= STABLE_LO;
              db    <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
              fall  <= 1'b1;
`endif
            end else begin
              state <= PEND_LO;
              cnt   <= CW'(1);
            end
          end
          PEND_LO: begin
            if (s2) begin
              state <= STABLE_HI;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state <= STABLE_LO;
              cnt   <= '0;
              db    <= 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
              fall  <= 1'b1;
`endif
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/btn_debounce_bank.sv
// Multi-channel button debouncer: shared sample-rate prescaler plus N_CH debounce_ch lanes.
// Define DEBOUNCE_FALL_PULSE_EN to add the btn_fall port.
module btn_debounce_bank
  import debounce_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int SAMPLE_HZ  = DEF_SAMPLE_HZ,
  parameter int N_CH       = 5,
  parameter int STABLE_CNT = 4
) (
  input  logic            clkin,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_db,
  output logic [N_CH-1:0] btn_rise,
  output logic            sample_tick
`ifdef DEBOUNCE_FALL_PULSE_EN
  ,
  output logic [N_CH-1:0] btn_fall
`endif
);

  localparam int            DIV  = CLK_HZ / SAMPLE_HZ;
  localparam int            PW   = clog2_min1(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  // Tick is a registered enable, high the cycle after cnt reaches DIV-1.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= (cnt == LAST);
      cnt         <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .STABLE_CNT(STABLE_CNT)
    ) u_ch (
      .clkin (clkin),
      .rst_n (rst_n),
      .tick  (sample_tick),
      .btn_in(btn_in[g]),
      .db    (btn_db[g]),
      .rise  (btn_rise[g])
`ifdef DEBOUNCE_FALL_PULSE_EN
      ,
      .fall  (btn_fall[g])
`endif
    );
  end

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Scoreboard bench for btn_debounce_bank (DIV=10, 3 channels, 3-sample filter).
// Fall-pulse checks are active when DEBOUNCE_FALL_PULSE_EN is defined.
module tb_btn_debounce_bank;

  localparam int N = 3;

  logic         clkin = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_db;
  logic [N-1:0] btn_rise;
  logic         sample_tick;
`ifdef DEBOUNCE_FALL_PULSE_EN
  logic [N-1:0] btn_fall;
`endif

  typedef struct {
    int           at;
    logic [N-1:0] db;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } ev_t;

  ev_t          exp_q[$];
  ev_t          e;
  int           n_chk = 0;
  int           n_err = 0;
  int           pcount;
  logic [N-1:0] prev_db;

  btn_debounce_bank #(
    .CLK_HZ    (1000),
    .SAMPLE_HZ (100),
    .N_CH      (N),
    .STABLE_CNT(3)
  ) dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .btn_db     (btn_db),
    .btn_rise   (btn_rise),
    .sample_tick(sample_tick)
`ifdef DEBOUNCE_FALL_PULSE_EN
    ,
    .btn_fall   (btn_fall)
`endif
  );

  always #5 clkin = ~clkin;

  // Posedges since reset release; value seen at a negedge = index of the preceding posedge.
  always @(posedge clkin or negedge rst_n)
    if (!rst_n) pcount <= 0;
    else        pcount <= pcount + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t pc=%0d)", tag, got, exp, $time, pcount);
    end
  endtask

  // Input driven after posedge p reaches s2 at p+2; first tick cycle ending at or after that,
  // two more ticks, and the output flips on the posedge closing the third tick cycle.
  function automatic int ev_at(input int p);
    int t;
    t = ((p + 2 + 9) / 10) * 10;
    return t + 20 + 1;
  endfunction

  task automatic expect_ev(input int p, input logic [N-1:0] db, input logic [N-1:0] rise,
                           input logic [N-1:0] fall);
    ev_t x;
    x.at = ev_at(p); x.db = db; x.rise = rise; x.fall = fall;
    exp_q.push_back(x);
  endtask

  task automatic drive_at(input int p, input logic [N-1:0] v);
    while (pcount < p) @(negedge clkin);
    btn_in = v;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clkin);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Monitor: tick schedule every cycle, and every output change pops one expected event.
  always @(negedge clkin) begin
    logic [N-1:0] fv;
`ifdef DEBOUNCE_FALL_PULSE_EN
    fv = btn_fall;
`else
    fv = '0;
`endif
    if (!rst_n) begin
      prev_db = '0;
    end else begin
      chk("tick", sample_tick, (pcount != 0 && pcount % 10 == 0));
      if (btn_db !== prev_db || btn_rise !== '0 || fv !== '0) begin
        if (exp_q.size() == 0) begin
          chk("spurious_db", btn_db, prev_db);
          chk("spurious_rise", btn_rise, 0);
`ifdef DEBOUNCE_FALL_PULSE_EN
          chk("spurious_fall", fv, 0);
`endif
        end else begin
          e = exp_q.pop_front();
          chk("ev_cycle", pcount, e.at);
          chk("ev_db", btn_db, e.db);
          chk("ev_rise", btn_rise, e.rise);
`ifdef DEBOUNCE_FALL_PULSE_EN
          chk("ev_fall", fv, e.fall);
`endif
        end
      end
      prev_db = btn_db;
    end
  end

  initial begin
    rst_n  = 1'b0;
    btn_in = '1;
    repeat (3) @(negedge clkin);
    chk("rst_db", btn_db, 0);
    chk("rst_rise", btn_rise, 0);
    chk("rst_tick", sample_tick, 0);
    btn_in = '0;
    rst_n  = 1'b1;

    // clean press on ch0
    drive_at(3, 3'b001);
    expect_ev(3, 3'b001, 3'b001, 3'b000);
    drain(60);

    // ch1 bounce: seen high on only two samples
    drive_at(43, 3'b011);
    drive_at(63, 3'b001);
    drive_at(100, 3'b001);
    chk("bounce_db", btn_db, 3'b001);

    // release ch0
    drive_at(103, 3'b000);
    expect_ev(103, 3'b000, 3'b000, 3'b001);
    drain(60);

    // all channels pressed, then released, in the same cycle
    drive_at(143, 3'b111);
    expect_ev(143, 3'b111, 3'b111, 3'b000);
    drain(60);
    drive_at(183, 3'b000);
    expect_ev(183, 3'b000, 3'b000, 3'b111);
    drain(60);

    // ch0 stable high, ch2 pending with two samples, then async reset
    drive_at(223, 3'b001);
    expect_ev(223, 3'b001, 3'b001, 3'b000);
    drain(60);
    drive_at(263, 3'b101);
    drive_at(285, 3'b101);
    #2 rst_n = 1'b0;
    #1;
    chk("async_db", btn_db, 0);
    chk("async_rise", btn_rise, 0);
    chk("async_tick", sample_tick, 0);
    @(negedge clkin);
    @(negedge clkin);
    rst_n = 1'b1;
    // both held channels need three fresh samples after release
    expect_ev(0, 3'b101, 3'b101, 3'b000);
    drain(60);

    repeat (15) @(negedge clkin);
    chk("q_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
